burst_master: RTL

BURST_MASTER -- requirements
Module: burst_master

---
 rtl/burst_master_pkg.sv | 18 +
 rtl/burst_master_if.sv | 42 ++++
 rtl/bit_serializer.sv | 36 +++
 rtl/burst_master.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/burst_master_pkg.sv
// Shared FSM state type and default sizes for the burst_master slice.
package burst_master_pkg;

  localparam int unsigned DefaultDataW  = 8;
  localparam int unsigned DefaultAddrW  = 14;
  localparam int unsigned DefaultBurstW = 3;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StWaitSlave,
    StWdata,
    StRdata,
    StDone
  } state_e;

endpackage

// File: rtl/burst_master_if.sv
// User, arbiter and slave side signals of burst_master, grouped as one bus.
interface burst_master_if import burst_master_pkg::*; #(
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned BURST_W = DefaultBurstW
) ();

  logic               enable;
  logic               read_en;
  logic [DATA_W-1:0]  data_in;
  logic [ADDR_W-1:0]  addr_in;
  logic [BURST_W-1:0] burst_mode_in;
  logic               data_rx;
  logic               slave_ready;
  logic               bus_ready;
  logic               slave_valid;
  logic               bus_req;
  logic               addr_tx;
  logic               data_tx;
  logic               valid;
  logic               rw;
  logic [BURST_W-1:0] burst_mode;
  logic               data_req;
  logic [DATA_W-1:0]  rdata;
  logic               rdata_valid;
  logic               master_busy;

  modport master (
    input  enable, read_en, data_in, addr_in, burst_mode_in, data_rx, slave_ready, bus_ready,
           slave_valid,
    output bus_req, addr_tx, data_tx, valid, rw, burst_mode, data_req, rdata, rdata_valid,
           master_busy
  );

  modport slave (
    output enable, read_en, data_in, addr_in, burst_mode_in, data_rx, slave_ready, bus_ready,
           slave_valid,
    input  bus_req, addr_tx, data_tx, valid, rw, burst_mode, data_req, rdata, rdata_valid,
           master_busy
  );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-load shift register, LSB out first, MSB in; done marks the last bit of a word.
module bit_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             hold,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] shreg,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shreg_q <= load_data;
      cnt_q   <= '0;
    end else if (!hold) begin
      shreg_q <= {serial_in, shreg_q[WIDTH-1:1]};
      cnt_q   <= done ? '0 : cnt_q + 1'b1;
    end
  end

  assign shreg = shreg_q;
  assign done  = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/burst_master.sv
// Serial bus master: request grant, shift address, then write or read data beats.
// Multi-beat bursts are built only with BURST_MASTER_BURST_EN; otherwise every transfer is one beat.
module burst_master import burst_master_pkg::*; #(
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned BURST_W = DefaultBurstW
) (
  input logic            clock,
  input logic            reset,
  burst_master_if.master bus
);

  state_e             state_q, state_d;
  logic               rw_q, rw_d;
  logic [BURST_W-1:0] burst_q, burst_d, burst_latch;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic               last_beat, beat_adv, tx_valid, data_req, bus_req;
  logic               addr_load, addr_shift, addr_done;
  logic               data_load, data_shift, data_done, data_sin;
  logic [ADDR_W-1:0]  addr_word;
  logic [DATA_W-1:0]  data_word;
  logic               unused_addr;

`ifdef BURST_MASTER_BURST_EN
  logic [BURST_W-1:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (state_q == StIdle) begin
      beat_d = '0;
    end else if (beat_adv) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) beat_q <= '0;
    else       beat_q <= beat_d;
  end

  assign last_beat   = (beat_q == burst_q);
  assign burst_latch = bus.burst_mode_in;
`else
  logic unused_burst;
  assign unused_burst = ^{bus.burst_mode_in, beat_adv};
  assign last_beat    = 1'b1;
  assign burst_latch  = '0;
`endif

  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    burst_d       = burst_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    bus_req       = 1'b0;
    tx_valid      = 1'b0;
    data_req      = 1'b0;
    beat_adv      = 1'b0;
    addr_load     = 1'b0;
    addr_shift    = 1'b0;
    data_load     = 1'b0;
    data_shift    = 1'b0;
    data_sin      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          rw_d      = bus.read_en;
          burst_d   = burst_latch;
          addr_load = 1'b1;
          data_load = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        bus_req = 1'b1;
        if (bus.bus_ready) state_d = StAddr;
      end
      StAddr: begin
        bus_req    = 1'b1;
        tx_valid   = bus.bus_ready;
        addr_shift = bus.bus_ready;
        if (bus.bus_ready && addr_done) state_d = StWaitSlave;
      end
      StWaitSlave: begin
        bus_req = 1'b1;
        if (bus.slave_ready && bus.bus_ready) state_d = rw_q ? StRdata : StWdata;
      end
      StWdata: begin
        bus_req    = 1'b1;
        tx_valid   = bus.bus_ready;
        data_shift = bus.bus_ready;
        if (bus.bus_ready && data_done) begin
          if (last_beat) begin
            state_d = StDone;
          end else begin
            // Next word is loaded on the same edge as the last shift, so beats abut.
            beat_adv  = 1'b1;
            data_req  = 1'b1;
            data_load = 1'b1;
          end
        end
      end
      StRdata: begin
        bus_req    = 1'b1;
        data_shift = bus.bus_ready && bus.slave_valid;
        data_sin   = bus.data_rx;
        if (data_shift && data_done) begin
          rdata_d       = {bus.data_rx, data_word[DATA_W-1:1]};
          rdata_valid_d = 1'b1;
          if (last_beat) state_d = StDone;
          else           beat_adv = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      rw_q          <= 1'b0;
      burst_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rw_q          <= rw_d;
      burst_q       <= burst_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  bit_serializer #(
    .WIDTH (ADDR_W)
  ) u_addr_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (addr_load),
    .hold      (!addr_shift),
    .serial_in (1'b0),
    .load_data (bus.addr_in),
    .shreg     (addr_word),
    .done      (addr_done)
  );

  // Shared by both directions: writes shift out, reads shift data_rx in at the MSB.
  bit_serializer #(
    .WIDTH (DATA_W)
  ) u_data_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (data_load),
    .hold      (!data_shift),
    .serial_in (data_sin),
    .load_data (bus.data_in),
    .shreg     (data_word),
    .done      (data_done)
  );

  assign unused_addr     = ^addr_word[ADDR_W-1:1];

  assign bus.bus_req     = bus_req;
  assign bus.valid       = tx_valid;
  assign bus.addr_tx     = tx_valid && (state_q == StAddr) && addr_word[0];
  assign bus.data_tx     = tx_valid && (state_q == StWdata) && data_word[0];
  assign bus.rw          = rw_q;
  assign bus.burst_mode  = burst_q;
  assign bus.data_req    = data_req;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.master_busy = (state_q != StIdle);

endmodule
